// File: rtl/pwm_cap_pkg.sv
// pwm_cap_pkg: shared types and widths for the servo PWM capture decoder.
//   state_e   - frame tracking FSM states
//   CNT_W     - width of the on-time/period counters
//   ANGLE_W   - width of the decoded angle code
//   ANGLE_MAX - largest angle code
package pwm_cap_pkg;
   typedef enum logic [1:0] {IDLE, HIGH, DECODE, LOW} state_e;
   localparam int CNT_W = 28;
   localparam int ANGLE_W = 4;
   localparam int ANGLE_MAX = 15;
endpackage

// File: rtl/pwm_in_conditioner.sv
// pwm_in_conditioner: synchronizes the async PWM line, optionally deglitches it, and
// produces the filtered level plus single-cycle rise/fall pulses.
//   clk, rst_n - clock, async active-low reset
//   pwm_i      - asynchronous PWM line
//   lvl_o      - conditioned level
//   rise_o     - one-cycle pulse on a 0->1 of lvl_o
//   fall_o     - one-cycle pulse on a 1->0 of lvl_o
// Macro PWM_GLITCH_FILTER_EN: lvl_o follows the synchronized input only after it has
// held a new value for FILT_LEN consecutive cycles.
module pwm_in_conditioner #(
   parameter int unsigned FILT_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);
   logic [1:0] sync_q;
   logic       prev_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], pwm_i};
         prev_q <= lvl_o;
      end
   end
`ifdef PWM_GLITCH_FILTER_EN
   localparam int unsigned CW = $clog2(FILT_LEN + 1);
   logic [CW-1:0] cnt_q;
   logic          lvl_q;
   // Count consecutive cycles the synchronized input disagrees with lvl_q; any
   // agreement restarts the count, so short pulses and gaps never get through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         lvl_q <= 1'b0;
      end else if (sync_q[1] == lvl_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
         cnt_q <= '0;
         lvl_q <= sync_q[1];
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end
   assign lvl_o = lvl_q;
`else
   assign lvl_o = sync_q[1];
`endif
   assign rise_o = lvl_o & ~prev_q;
   assign fall_o = ~lvl_o & prev_q;
endmodule

// File: rtl/pwm_capture_decoder.sv
// pwm_capture_decoder: measures high time and period of a servo PWM line, validates
// the frame against servo limits and decodes the high time back to a 4-bit angle code.
//   clk, rst_n   - clock, async active-low reset
//   pwm_in       - asynchronous PWM line
//   on_time      - last valid high time in cycles
//   period       - last valid rising-to-rising period in cycles
//   angle        - decoded angle code of the last valid frame
//   sample_valid - one-cycle strobe when the outputs above are updated
//   locked       - the last frame was valid
//   frame_err    - one-cycle strobe on a rejected frame or timeout
// Macro PWM_GLITCH_FILTER_EN enables the FILT_LEN glitch filter on the input.
module pwm_capture_decoder
   import pwm_cap_pkg::*;
#(
   parameter int unsigned ON_MIN     = 100_000,
   parameter int unsigned ON_STEP    = 6_667,
   parameter int unsigned PERIOD_MIN = 1_800_000,
   parameter int unsigned PERIOD_MAX = 2_200_000,
   parameter int unsigned FILT_LEN   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pwm_in,
   output logic [CNT_W-1:0]   on_time,
   output logic [CNT_W-1:0]   period,
   output logic [ANGLE_W-1:0] angle,
   output logic               sample_valid,
   output logic               locked,
   output logic               frame_err
);
   localparam logic [CNT_W-1:0]   STEP  = CNT_W'(ON_STEP);
   localparam logic [CNT_W-1:0]   HALF  = CNT_W'(ON_STEP / 2);
   localparam logic [CNT_W-1:0]   OMIN  = CNT_W'(ON_MIN);
   localparam logic [CNT_W-1:0]   HI_LO = CNT_W'(ON_MIN - ON_STEP / 2);
   localparam logic [CNT_W-1:0]   HI_HI = CNT_W'(ON_MIN + ANGLE_MAX * ON_STEP + ON_STEP / 2);
   localparam logic [CNT_W-1:0]   P_MIN = CNT_W'(PERIOD_MIN);
   localparam logic [CNT_W-1:0]   P_MAX = CNT_W'(PERIOD_MAX);
   localparam logic [ANGLE_W-1:0] Q_MAX = ANGLE_W'(ANGLE_MAX);

   logic lvl, rise, fall;
`ifdef PWM_GLITCH_FILTER_EN
   pwm_in_conditioner #(.FILT_LEN(FILT_LEN)) u_cond (
`else
   pwm_in_conditioner u_cond (
`endif
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_i  (pwm_in),
      .lvl_o  (lvl),
      .rise_o (rise),
      .fall_o (fall)
   );

   state_e             state_q;
   logic [CNT_W-1:0]   hi_cnt_q, per_cnt_q, hi_lat_q, rem_q, on_time_q, period_q;
   logic [ANGLE_W-1:0] q_q, q_lat_q, angle_q;
   logic               sample_valid_q, locked_q, frame_err_q;
   logic               timeout;

   assign timeout = per_cnt_q >= P_MAX;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         hi_cnt_q       <= '0;
         per_cnt_q      <= '0;
         hi_lat_q       <= '0;
         rem_q          <= '0;
         q_q            <= '0;
         q_lat_q        <= '0;
         on_time_q      <= '0;
         period_q       <= '0;
         angle_q        <= '0;
         sample_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
         if (state_q != IDLE) per_cnt_q <= per_cnt_q + 1'b1;
         if (state_q == HIGH && lvl) hi_cnt_q <= hi_cnt_q + 1'b1;
         // Later assignments in the case override the free-running increments above,
         // so a rise restarts both counters at 1 (the rise cycle itself).
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  hi_cnt_q  <= CNT_W'(1);
                  per_cnt_q <= CNT_W'(1);
                  state_q   <= HIGH;
               end
            end
            HIGH: begin
               if (timeout) begin
                  frame_err_q <= 1'b1;
                  locked_q    <= 1'b0;
                  state_q     <= IDLE;
               end else if (fall) begin
                  hi_lat_q <= hi_cnt_q;
                  if (hi_cnt_q >= HI_LO && hi_cnt_q < HI_HI) begin
                     // Bias by half a step so the quotient rounds to the nearest code.
                     rem_q   <= hi_cnt_q - OMIN + HALF;
                     q_q     <= '0;
                     state_q <= DECODE;
                  end else begin
                     frame_err_q <= 1'b1;
                     locked_q    <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            DECODE: begin
               if (rise) begin
                  frame_err_q <= 1'b1;
                  locked_q    <= 1'b0;
                  hi_cnt_q    <= CNT_W'(1);
                  per_cnt_q   <= CNT_W'(1);
                  state_q     <= HIGH;
               end else if (timeout) begin
                  frame_err_q <= 1'b1;
                  locked_q    <= 1'b0;
                  state_q     <= IDLE;
               end else if (rem_q >= STEP && q_q < Q_MAX) begin
                  rem_q <= rem_q - STEP;
                  q_q   <= q_q + 1'b1;
               end else begin
                  q_lat_q <= q_q;
                  state_q <= LOW;
               end
            end
            LOW: begin
               if (rise) begin
                  if (per_cnt_q >= P_MIN && per_cnt_q <= P_MAX) begin
                     on_time_q      <= hi_lat_q;
                     period_q       <= per_cnt_q;
                     angle_q        <= q_lat_q;
                     sample_valid_q <= 1'b1;
                     locked_q       <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                     locked_q    <= 1'b0;
                  end
                  hi_cnt_q  <= CNT_W'(1);
                  per_cnt_q <= CNT_W'(1);
                  state_q   <= HIGH;
               end else if (timeout) begin
                  frame_err_q <= 1'b1;
                  locked_q    <= 1'b0;
                  state_q     <= IDLE;
               end
            end
         endcase
      end
   end

   assign on_time      = on_time_q;
   assign period       = period_q;
   assign angle        = angle_q;
   assign sample_valid = sample_valid_q;
   assign locked       = locked_q;
   assign frame_err    = frame_err_q;
endmodule

// File: tb/tb_pwm_capture_decoder.sv
// tb_pwm_capture_decoder: directed self-checking bench for pwm_capture_decoder.
module tb_pwm_capture_decoder;
   import pwm_cap_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               pwm_in = 1'b0;
   logic [CNT_W-1:0]   on_time, period;
   logic [ANGLE_W-1:0] angle;
   logic               sample_valid, locked, frame_err;

   int checks = 0;
   int errors = 0;
   int sv_cnt = 0;
   int fe_cnt = 0;

   pwm_capture_decoder #(
      .ON_MIN(100), .ON_STEP(10), .PERIOD_MIN(900), .PERIOD_MAX(1100), .FILT_LEN(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
      .on_time(on_time), .period(period), .angle(angle),
      .sample_valid(sample_valid), .locked(locked), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sample_valid === 1'b1) sv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
      if (sample_valid === 1'b1 && frame_err === 1'b1) begin
         errors++;
         $display("FAIL strobe_overlap: sample_valid and frame_err both 1 at %0t", $time);
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input int h, input int p);
      pwm_in = 1'b1;
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (p - h) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (on_time !== '0) begin errors++; $display("FAIL reset_on_time: got %0d expected 0", on_time); end
      checks++; if (period !== '0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period); end
      checks++; if (angle !== '0) begin errors++; $display("FAIL reset_angle: got %0d expected 0", angle); end
      checks++; if ({sample_valid, locked, frame_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {sample_valid, locked, frame_err}); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
   endtask

   task automatic test_nominal();
      int sv0, fe0;
      do_reset();
      sv0 = sv_cnt; fe0 = fe_cnt;
      send_frame(130, 1000);
      pwm_in = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", sample_valid); end
      @(negedge clk);
      checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL latency_strobe: got %b expected 1", sample_valid); end
      checks++; if (on_time !== 28'd130 || period !== 28'd1000 || angle !== 4'd3) begin errors++; $display("FAIL strobe_outputs: got %0d/%0d/%0d expected 130/1000/3", on_time, period, angle); end
      repeat (127) @(negedge clk);
      pwm_in = 1'b0;
      repeat (870) @(negedge clk);
      send_frame(130, 1000);
      send_frame(130, 1000);
      checks++; if (sv_cnt - sv0 !== 3) begin errors++; $display("FAIL nominal_count: got %0d expected 3", sv_cnt - sv0); end
      checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL nominal_err: got %0d expected 0", fe_cnt - fe0); end
      checks++; if (on_time !== 28'd130 || period !== 28'd1000 || angle !== 4'd3 || locked !== 1'b1) begin errors++; $display("FAIL nominal_outputs: got %0d/%0d/%0d/%b expected 130/1000/3/1", on_time, period, angle, locked); end
   endtask

   task automatic test_angles();
      int hs[3] = '{95, 250, 104};
      int as[3] = '{0, 15, 0};
      int sv0;
      for (int i = 0; i < 3; i++) begin
         do_reset();
         sv0 = sv_cnt;
         send_frame(hs[i], 1000);
         send_frame(hs[i], 1000);
         checks++; if (sv_cnt - sv0 !== 1) begin errors++; $display("FAIL angle_count_%0d: got %0d expected 1", hs[i], sv_cnt - sv0); end
         checks++; if (angle !== 4'(as[i]) || on_time !== 28'(hs[i]) || locked !== 1'b1) begin errors++; $display("FAIL angle_%0d: got %0d/%0d/%b expected %0d/%0d/1", hs[i], angle, on_time, locked, as[i], hs[i]); end
      end
   endtask

   task automatic test_bad_high();
      int hs[2] = '{94, 255};
      int sv0, fe0;
      for (int i = 0; i < 2; i++) begin
         do_reset();
         sv0 = sv_cnt; fe0 = fe_cnt;
         send_frame(130, 1000);
         send_frame(hs[i], 1000);
         send_frame(130, 1000);
         checks++; if (sv_cnt - sv0 !== 1 || fe_cnt - fe0 !== 1) begin errors++; $display("FAIL bad_high_%0d_counts: got sv=%0d fe=%0d expected sv=1 fe=1", hs[i], sv_cnt - sv0, fe_cnt - fe0); end
         checks++; if (locked !== 1'b0 || on_time !== 28'd130 || angle !== 4'd3) begin errors++; $display("FAIL bad_high_%0d_held: got %b/%0d/%0d expected 0/130/3", hs[i], locked, on_time, angle); end
      end
   endtask

   task automatic test_short_period();
      int sv0, fe0;
      do_reset();
      sv0 = sv_cnt; fe0 = fe_cnt;
      send_frame(130, 1000);
      send_frame(130, 800);
      send_frame(130, 1000);
      checks++; if (sv_cnt - sv0 !== 1 || fe_cnt - fe0 !== 1) begin errors++; $display("FAIL short_period_counts: got sv=%0d fe=%0d expected sv=1 fe=1", sv_cnt - sv0, fe_cnt - fe0); end
      checks++; if (locked !== 1'b0 || period !== 28'd1000) begin errors++; $display("FAIL short_period_held: got %b/%0d expected 0/1000", locked, period); end
   endtask

   task automatic test_timeout();
      int sv0, fe0;
      do_reset();
      sv0 = sv_cnt; fe0 = fe_cnt;
      pwm_in = 1'b1;
      repeat (1200) @(negedge clk);
      checks++; if (fe_cnt - fe0 !== 1 || locked !== 1'b0) begin errors++; $display("FAIL timeout_err: got fe=%0d locked=%b expected fe=1 locked=0", fe_cnt - fe0, locked); end
      checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL timeout_state: got %0d expected %0d", dut.state_q, IDLE); end
      pwm_in = 1'b0;
      repeat (100) @(negedge clk);
      send_frame(130, 1000);
      send_frame(130, 1000);
      checks++; if (sv_cnt - sv0 !== 1 || fe_cnt - fe0 !== 1 || locked !== 1'b1) begin errors++; $display("FAIL timeout_relock: got sv=%0d fe=%0d locked=%b expected 1/1/1", sv_cnt - sv0, fe_cnt - fe0, locked); end
   endtask

   task automatic test_mid_reset();
      int sv0, fe0;
      do_reset();
      sv0 = sv_cnt; fe0 = fe_cnt;
      send_frame(130, 1000);
      pwm_in = 1'b1;
      repeat (50) @(negedge clk);
      checks++; if (sv_cnt - sv0 !== 1 || locked !== 1'b1) begin errors++; $display("FAIL pre_reset: got sv=%0d locked=%b expected 1/1", sv_cnt - sv0, locked); end
      rst_n = 1'b0;
      #1;
      checks++; if (on_time !== '0 || period !== '0 || angle !== '0 || {sample_valid, locked, frame_err} !== 3'b000) begin errors++; $display("FAIL mid_reset_clear: got %0d/%0d/%0d/%b expected 0/0/0/000", on_time, period, angle, {sample_valid, locked, frame_err}); end
      repeat (80) @(negedge clk);
      pwm_in = 1'b0;
      repeat (100) @(negedge clk);
      rst_n = 1'b1;
      repeat (770) @(negedge clk);
      send_frame(130, 1000);
      send_frame(130, 1000);
      checks++; if (sv_cnt - sv0 !== 2 || fe_cnt - fe0 !== 0) begin errors++; $display("FAIL mid_reset_counts: got sv=%0d fe=%0d expected 2/0", sv_cnt - sv0, fe_cnt - fe0); end
      checks++; if (on_time !== 28'd130 || period !== 28'd1000 || angle !== 4'd3 || locked !== 1'b1) begin errors++; $display("FAIL mid_reset_frame: got %0d/%0d/%0d/%b expected 130/1000/3/1", on_time, period, angle, locked); end
   endtask

   task automatic test_glitch();
      int sv0, fe0;
      do_reset();
      sv0 = sv_cnt; fe0 = fe_cnt;
      pwm_in = 1'b1; repeat (40) @(negedge clk);
      pwm_in = 1'b0; repeat (2) @(negedge clk);
      pwm_in = 1'b1; repeat (40) @(negedge clk);
      pwm_in = 1'b0; repeat (2) @(negedge clk);
      pwm_in = 1'b1; repeat (46) @(negedge clk);
      pwm_in = 1'b0; repeat (870) @(negedge clk);
      send_frame(130, 1000);
`ifdef PWM_GLITCH_FILTER_EN
      checks++; if (sv_cnt - sv0 !== 1 || fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_counts: got sv=%0d fe=%0d expected 1/0", sv_cnt - sv0, fe_cnt - fe0); end
      checks++; if (on_time !== 28'd130 || angle !== 4'd3 || locked !== 1'b1) begin errors++; $display("FAIL glitch_filtered: got %0d/%0d/%b expected 130/3/1", on_time, angle, locked); end
`else
      checks++; if (sv_cnt - sv0 !== 0 || fe_cnt - fe0 !== 3) begin errors++; $display("FAIL glitch_counts: got sv=%0d fe=%0d expected 0/3", sv_cnt - sv0, fe_cnt - fe0); end
      checks++; if (locked !== 1'b0 || on_time !== 28'd0) begin errors++; $display("FAIL glitch_unfiltered: got %b/%0d expected 0/0", locked, on_time); end
`endif
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_angles();
      test_bad_high();
      test_short_period();
      test_timeout();
      test_mid_reset();
      test_glitch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
